dbg_io_master: RTL and testbench
================================

# dbg_io_master

Debugger-side initiator for the shared 6-bit AVR I/O bus. It accepts single read or write commands from the debug host logic and drives the debugger port of the I/O arbiter (address, read/write strobes, write data). It holds the access while the arbiter reports the core owns the bus (`d_wait`), then returns read data or write completion on a response handshake. It sits in the external debug unit between the debug command decoder and the I/O arbiter.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum consecutive `d_wait` cycles before an access is aborted. Range 1..255. Used only when the timeout feature is compiled in.

Ports:
- `cp2`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  host presents a command.
- `cmd_ready`  out  1  block accepts a command this cycle.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_adr`  in  6  I/O address.
- `cmd_wdata`  in  8  write data.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  host consumes the response.
- `rsp_rdata`  out  8  read data; 0x00 for writes and errors.
- `rsp_err`  out  1  access aborted by timeout.
- `d_adr`  out  6  address to the arbiter.
- `d_iore`  out  1  read strobe to the arbiter.
- `d_iowe`  out  1  write strobe to the arbiter.
- `d_dbusout`  out  8  write data to the arbiter.
- `d_wait`  in  1  core owns the bus; the current strobe was not serviced.
- `dbusin`  in  8  I/O read data bus, valid in the same cycle as address and strobe.

## Operation
- FSM states: IDLE, ACC, RSP. Reset state is IDLE.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch `cmd_we`, `cmd_adr` and `cmd_wdata`, clear the wait counter, and go to ACC.
- ACC: `d_adr` and `d_dbusout` come from the latched registers. `d_iore`=!we and `d_iowe`=we, both derived only from state and latched registers (no combinational path from `cmd_*`).
  - `d_wait`=0: the access completes this cycle. For a read, `rsp_rdata` captures `dbusin` at the closing edge; for a write, `rsp_rdata` is set to 0x00. `rsp_err`=0. Go to RSP.
  - `d_wait`=1: stay in ACC with strobes held and increment the wait counter.
- RSP: `rsp_valid`=1, and `rsp_rdata`/`rsp_err` are stable. On `rsp_ready`=1, go to IDLE. `rsp_ready` outside RSP is ignored.
- Only one command is outstanding at a time. `cmd_ready`=0 in ACC and RSP.
- In states other than ACC, `d_iore`=`d_iowe`=0. `d_adr` and `d_dbusout` keep their last latched values.
- Wait counter is 8 bits wide and saturates; it never wraps.

## Timing
- Reset values: `cmd_ready`=0 while `rst`=1, then 1 in the first cycle after release. `rsp_valid`=0, `rsp_rdata`=0x00, `rsp_err`=0, `d_iore`=0, `d_iowe`=0, `d_adr`=0, `d_dbusout`=0x00.
- Minimum latency: command accepted at edge N; strobe is high in cycle N..N+1; response is valid from edge N+1 if `d_wait`=0.
- Each `d_wait` cycle adds one cycle of latency. The strobe is asserted for exactly 1 + (number of wait cycles) cycles.
- `rsp_ready` already high on entry to RSP: `rsp_valid` is high for exactly one cycle. A new command is accepted no earlier than the cycle after return to IDLE, so there are at least 3 cycles per access.
- `rst` asserted mid-access: strobes are 0 and the FSM is in IDLE after the next edge, and the latched command is discarded. No response is produced.
- `d_wait` toggling mid-access: only the cycle with `d_wait`=0 completes the access. Write data is applied exactly once.

## Configuration
- `DBG_IO_TIMEOUT_EN` defined: if `d_wait`=1 in ACC and the wait counter equals `TIMEOUT`-1, the access is abandoned at that edge. The FSM goes to RSP with `rsp_err`=1 and `rsp_rdata`=0x00, and strobes drop.
- Not defined: no timeout. ACC waits indefinitely, `rsp_err` is constant 0, the wait counter is not implemented, and `TIMEOUT` is unused.

## Test plan
- Write, no contention: cmd (we=1, adr=0x3F, wdata=0xA5), `d_wait`=0 -> `d_iowe`=1 with adr 0x3F and data 0xA5 for exactly one cycle; `rsp_valid` next cycle, `rsp_rdata`=0x00, `rsp_err`=0.
- Read with contention: cmd (we=0, adr=0x12), `d_wait`=1 for 3 cycles, then `dbusin`=0x5C -> `d_iore` high for 4 cycles; `rsp_rdata`=0x5C.
- Response backpressure: `rsp_ready` held low for 5 cycles -> `rsp_valid` and data stable, `cmd_ready`=0 throughout; IDLE the cycle after `rsp_ready`=1.
- Timeout (macro on, `TIMEOUT`=4): `d_wait` held at 1 -> strobe high exactly 4 cycles, then `rsp_err`=1 and `rsp_rdata`=0x00. Macro off: strobe stays high for 300 cycles with no response.
- Reset mid-ACC: `rst` pulsed for 1 cycle during a wait -> all outputs at reset values next cycle, no `rsp_valid`, and the next command is accepted normally.
- Back-to-back: two commands queued on `cmd_valid` with `rsp_ready`=1 -> second accepted exactly 3 cycles after the first, with no strobe overlap.

Source files
------------

// File: rtl/dbg_io_master.sv
// Debugger-side initiator for the shared 6-bit AVR I/O bus: one read/write command at a time,
// held while d_wait is asserted. Optional abort on long contention via `DBG_IO_TIMEOUT_EN.
module dbg_io_master #(
  parameter int TIMEOUT = 255
) (
  input  logic       cp2,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [5:0] cmd_adr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [5:0] d_adr,
  output logic       d_iore,
  output logic       d_iowe,
  output logic [7:0] d_dbusout,
  input  logic       d_wait,
  input  logic [7:0] dbusin
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_r;
  state_t      next_state_s;
  logic        accept_s;
  logic        timeout_hit_s;

  logic        cmd_ready_r;
  logic        rsp_valid_r;
  logic        iore_r;
  logic        iowe_r;
  logic        we_r;
  logic [5:0]  adr_r;
  logic [7:0]  wdata_r;
  logic [7:0]  rdata_r;
  logic        err_r;

  logic        cmd_ready_nxt_s;
  logic        rsp_valid_nxt_s;
  logic        iore_nxt_s;
  logic        iowe_nxt_s;
  logic        we_nxt_s;
  logic [5:0]  adr_nxt_s;
  logic [7:0]  wdata_nxt_s;
  logic [7:0]  rdata_nxt_s;
  logic        err_nxt_s;

  // cmd_ready_r stays low for the first cycle after reset, so it gates the handshake too
  assign accept_s = (state_r == ST_IDLE) && cmd_ready_r && cmd_valid;

`ifdef DBG_IO_TIMEOUT_EN
  logic [7:0] wait_cnt_r;

  // Saturating count of consecutive d_wait cycles in the current access
  always_ff @(posedge cp2) begin
    if (rst) begin
      wait_cnt_r <= 8'd0;
    end else if (accept_s) begin
      wait_cnt_r <= 8'd0;
    end else if ((state_r == ST_ACC) && d_wait && (wait_cnt_r != 8'hFF)) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign timeout_hit_s = d_wait && (wait_cnt_r == TMO_LAST);
`else
  logic unused_tmo_s;
  assign unused_tmo_s  = ^TMO_LAST;
  assign timeout_hit_s = 1'b0;
`endif

  // State register
  always_ff @(posedge cp2) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = ST_ACC;
        else          next_state_s = ST_IDLE;
      end
      ST_ACC: begin
        if (!d_wait)            next_state_s = ST_RSP;
        else if (timeout_hit_s) next_state_s = ST_RSP;
        else                    next_state_s = ST_ACC;
      end
      ST_RSP: begin
        if (rsp_ready) next_state_s = ST_IDLE;
        else           next_state_s = ST_RSP;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values; strobes derive from next state and latched direction only
  always_comb begin
    we_nxt_s    = we_r;
    adr_nxt_s   = adr_r;
    wdata_nxt_s = wdata_r;
    rdata_nxt_s = rdata_r;
    err_nxt_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          we_nxt_s    = cmd_we;
          adr_nxt_s   = cmd_adr;
          wdata_nxt_s = cmd_wdata;
        end else begin
          we_nxt_s    = we_r;
          adr_nxt_s   = adr_r;
          wdata_nxt_s = wdata_r;
        end
      end
      ST_ACC: begin
        if (!d_wait) begin
          rdata_nxt_s = we_r ? 8'h00 : dbusin;
          err_nxt_s   = 1'b0;
        end else if (timeout_hit_s) begin
          rdata_nxt_s = 8'h00;
          err_nxt_s   = 1'b1;
        end else begin
          rdata_nxt_s = rdata_r;
          err_nxt_s   = err_r;
        end
      end
      ST_RSP: begin
        rdata_nxt_s = rdata_r;
        err_nxt_s   = err_r;
      end
      default: begin
        rdata_nxt_s = 8'h00;
        err_nxt_s   = 1'b0;
      end
    endcase
    cmd_ready_nxt_s = (next_state_s == ST_IDLE);
    rsp_valid_nxt_s = (next_state_s == ST_RSP);
    iore_nxt_s      = (next_state_s == ST_ACC) && !we_nxt_s;
    iowe_nxt_s      = (next_state_s == ST_ACC) && we_nxt_s;
  end

  // Output and command registers
  always_ff @(posedge cp2) begin
    if (rst) begin
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      iore_r      <= 1'b0;
      iowe_r      <= 1'b0;
      we_r        <= 1'b0;
      adr_r       <= 6'd0;
      wdata_r     <= 8'h00;
      rdata_r     <= 8'h00;
      err_r       <= 1'b0;
    end else begin
      cmd_ready_r <= cmd_ready_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      iore_r      <= iore_nxt_s;
      iowe_r      <= iowe_nxt_s;
      we_r        <= we_nxt_s;
      adr_r       <= adr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      rdata_r     <= rdata_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;
  assign d_iore    = iore_r;
  assign d_iowe    = iowe_r;
  assign d_adr     = adr_r;
  assign d_dbusout = wdata_r;

endmodule

// File: tb/tb_dbg_io_master.sv
// Scoreboard bench for dbg_io_master: driver pushes expected responses, a negedge monitor
// pops and compares them on every response handshake and tracks strobe run lengths.
module tb_dbg_io_master;
  logic       cp2 = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_we = 1'b0;
  logic [5:0] cmd_adr = 6'd0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [5:0] d_adr;
  logic       d_iore;
  logic       d_iowe;
  logic [7:0] d_dbusout;
  logic       d_wait = 1'b0;
  logic [7:0] dbusin = 8'h00;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  int rd_run = 0, wr_run = 0, rd_run_last = 0, wr_run_last = 0;
  int overlap = 0, wr_applied = 0;

  dbg_io_master #(.TIMEOUT(4)) dut (
    .cp2(cp2), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .d_adr(d_adr), .d_iore(d_iore), .d_iowe(d_iowe),
    .d_dbusout(d_dbusout), .d_wait(d_wait), .dbusin(dbusin)
  );

  always #5 cp2 = ~cp2;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge cp2);
    #1;
  endtask

  task automatic issue(input logic we, input logic [5:0] adr, input logic [7:0] wd,
                       input bit push, input logic [7:0] exp_rd, input logic exp_err);
    int n;
    cmd_we = we;
    cmd_adr = adr;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    if (push) exp_q.push_back({exp_err, exp_rd});
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!cmd_ready) check("accept_bound", 0, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_d_iore"}, d_iore, 0);
    check({tag, "_d_iowe"}, d_iowe, 0);
    check({tag, "_d_adr"}, d_adr, 0);
    check({tag, "_d_dbusout"}, d_dbusout, 0);
  endtask

  // Monitor: response scoreboard plus strobe bookkeeping
  always @(negedge cp2) begin
    logic [8:0] e;
    if (d_iore) rd_run++;
    else if (rd_run != 0) begin rd_run_last = rd_run; rd_run = 0; end
    if (d_iowe) wr_run++;
    else if (wr_run != 0) begin wr_run_last = wr_run; wr_run = 0; end
    if (d_iore && d_iowe) overlap++;
    if (d_iowe && !d_wait) wr_applied++;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e[7:0]);
        check("rsp_err", rsp_err, e[8]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int bad;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    check("ready_after_reset", cmd_ready, 1);

    // Write, no contention
    issue(1'b1, 6'h3F, 8'hA5, 1'b1, 8'h00, 1'b0);
    check("wr_iowe", d_iowe, 1);
    check("wr_iore", d_iore, 0);
    check("wr_adr", d_adr, 6'h3F);
    check("wr_data", d_dbusout, 8'hA5);
    check("wr_no_rsp_yet", rsp_valid, 0);
    step();
    check("wr_iowe_drop", d_iowe, 0);
    check("wr_rsp_valid", rsp_valid, 1);
    step();
    check("wr_rsp_gone", rsp_valid, 0);
    check("wr_ready_again", cmd_ready, 1);
    check("wr_strobe_len", wr_run_last, 1);

    // Read with 3 wait cycles
    d_wait = 1'b1;
    issue(1'b0, 6'h12, 8'h00, 1'b1, 8'h5C, 1'b0);
    check("rd_iore", d_iore, 1);
    check("rd_adr", d_adr, 6'h12);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rd_iore_held", d_iore, 1);
      check("rd_no_rsp", rsp_valid, 0);
    end
    d_wait = 1'b0;
    dbusin = 8'h5C;
    step();
    check("rd_iore_drop", d_iore, 0);
    check("rd_rsp_valid", rsp_valid, 1);
    dbusin = 8'h00;
    step();
    check("rd_strobe_len", rd_run_last, 4);

    // Response backpressure
    rsp_ready = 1'b0;
    dbusin = 8'h81;
    issue(1'b0, 6'h05, 8'h00, 1'b1, 8'h81, 1'b0);
    step();
    dbusin = 8'h00;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 8'h81);
      check("bp_cmd_ready", cmd_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp_rsp_gone", rsp_valid, 0);
    check("bp_idle", cmd_ready, 1);

    // Back-to-back: second command waiting on cmd_valid
    dbusin = 8'h77;
    issue(1'b1, 6'h01, 8'h11, 1'b1, 8'h00, 1'b0);
    cmd_valid = 1'b1;
    cmd_we = 1'b0;
    cmd_adr = 6'h02;
    exp_q.push_back({1'b0, 8'h77});
    cnt = 0;
    while (!cmd_ready && cnt < 20) begin
      step();
      cnt++;
    end
    check("b2b_idle_strobes", {31'd0, d_iore | d_iowe}, 0);
    step();
    cnt++;
    cmd_valid = 1'b0;
    check("b2b_spacing", cnt, 3);
    check("b2b_second_iore", d_iore, 1);
    repeat (2) step();
    check("b2b_rd_len", rd_run_last, 1);
    check("b2b_wr_len", wr_run_last, 1);
    dbusin = 8'h00;

`ifdef DBG_IO_TIMEOUT_EN
    // Timeout after TIMEOUT strobe cycles
    d_wait = 1'b1;
    dbusin = 8'hEE;
    issue(1'b0, 6'h20, 8'h00, 1'b1, 8'h00, 1'b1);
    cnt = 0;
    while (d_iore && cnt < 20) begin
      cnt++;
      step();
    end
    check("tmo_strobe_len", cnt, 4);
    check("tmo_rsp_valid", rsp_valid, 1);
    check("tmo_rsp_err", rsp_err, 1);
    check("tmo_rsp_rdata", rsp_rdata, 0);
    step();
    dbusin = 8'h00;
`endif

    // Reset in the middle of a stalled access
    d_wait = 1'b1;
    issue(1'b0, 6'h33, 8'h00, 1'b0, 8'h00, 1'b0);
`ifndef DBG_IO_TIMEOUT_EN
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (!d_iore || rsp_valid) bad++;
      step();
    end
    check("no_timeout_hold", bad, 0);
`else
    repeat (2) step();
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midrst");
    d_wait = 1'b0;
    step();
    check("midrst_ready", cmd_ready, 1);
    issue(1'b1, 6'h2A, 8'h96, 1'b1, 8'h00, 1'b0);
    check("post_rst_iowe", d_iowe, 1);
    check("post_rst_data", d_dbusout, 8'h96);
    repeat (4) step();

    check("sb_drained", exp_q.size(), 0);
    check("strobe_overlap", overlap, 0);
    check("writes_applied", wr_applied, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
